// File: rtl/sysmem_ctrl.sv
// sysmem_ctrl: picorv32 native-bus bridge onto four byte-lane BRAMs (1024 x 8)
// that together form a 4 KiB system memory window at BASE_ADDR.
// Optional feature macro: SYSMEM_RDATA_REG_EN. When it is defined, read data is
// captured into a register (read latency 2). When it is undefined, read data is
// passed straight through from the BRAM (read latency 1).
module sysmem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic [AW-1:0] bram_addr,
    output logic [3:0]    bram_ce,
    output logic [3:0]    bram_we,
    output logic [31:0]   bram_di,
    input  logic [31:0]   bram_do,
    output logic          bram_rst
);

`ifdef SYSMEM_RDATA_REG_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_RDREG = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1} state_t;
`endif

    state_t state_q, state_d;
    logic   mem_ready_q, mem_ready_d;
    logic   hit_s;
    logic   unused_s;

    // Byte offset within the word and the window-internal upper bits are not decoded.
    assign unused_s = ^{mem_addr[1:0], mem_addr[11:2]};

    assign hit_s     = mem_valid & (mem_addr[31:12] == BASE_ADDR[31:12]);
    assign bram_addr = mem_addr[AW+1:2];
    assign bram_di   = mem_wdata;
    assign bram_rst  = 1'b0;
    assign mem_ready = mem_ready_q;

    // Next-state and BRAM strobes; strobes are only ever raised in the IDLE issue cycle.
    always_comb begin
        state_d = state_q;
        bram_ce = 4'h0;
        bram_we = 4'h0;
        case (state_q)
            S_IDLE: begin
                // resetn gates the issue so the BRAM sees no strobes while reset is held.
                if (hit_s && !mem_ready_q && resetn) begin
                    bram_ce = (mem_wstrb == 4'h0) ? 4'hF : mem_wstrb;
                    bram_we = mem_wstrb;
`ifdef SYSMEM_RDATA_REG_EN
                    state_d = (mem_wstrb == 4'h0) ? S_RDREG : S_ACK;
`else
                    state_d = S_ACK;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef SYSMEM_RDATA_REG_EN
            S_RDREG: state_d = S_ACK;
`endif
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // mem_ready is high exactly while the FSM sits in ACK.
    always_comb begin
        mem_ready_d = (state_d == S_ACK);
    end

    // State and completion-pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= mem_ready_d;
        end
    end

`ifdef SYSMEM_RDATA_REG_EN
    logic [31:0] rdata_q;

    // Capture BRAM read data in RDREG and hold it until the next read capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'h0000_0000;
        end else if (state_q == S_RDREG) begin
            rdata_q <= bram_do;
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign mem_rdata = rdata_q;
`else
    assign mem_rdata = bram_do;
`endif

endmodule

// File: tb/tb_sysmem_ctrl.sv
// Self-checking bench for sysmem_ctrl. A behavioural four-lane BRAM backs the
// DUT, a word-level reference memory predicts read data, and a scoreboard queue
// pairs each issued request with the mem_ready pulse that completes it.
module tb_sysmem_ctrl;

`ifdef SYSMEM_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] BOOT_WORD = 32'hB007_C0DE;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [9:0]  bram_addr;
    logic [3:0]  bram_ce;
    logic [3:0]  bram_we;
    logic [31:0] bram_di;
    logic [31:0] bram_do;
    logic        bram_rst;

    int checks_cnt   = 0;
    int failures_cnt = 0;
    int ready_cnt    = 0;
    int exp_ready    = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0]  lane_mem [4][1024];
    logic [31:0] ref_mem  [1024];

    sysmem_ctrl #(.BASE_ADDR(32'h0000_0000), .AW(10)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bram_addr (bram_addr),
        .bram_ce   (bram_ce),
        .bram_we   (bram_we),
        .bram_di   (bram_di),
        .bram_do   (bram_do),
        .bram_rst  (bram_rst)
    );

    always #5 clk = ~clk;

    // Behavioural byte-lane BRAMs: read-first, output updates one edge after ce.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (bram_ce[n]) begin
                bram_do[8*n +: 8] <= lane_mem[n][bram_addr];
                if (bram_we[n]) lane_mem[n][bram_addr] <= bram_di[8*n +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every mem_ready pulse retires the oldest issued request.
    always @(negedge clk) begin
        if (resetn && mem_ready) begin
            ready_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("spurious_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_read) check_eq("rdata", mem_rdata, e.data);
            end
        end
    end

    // Drive one request, wait (bounded) for its issue, check the BRAM strobes,
    // then check mem_ready rises exactly LAT cycles after issue.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit drop);
        exp_t        e;
        logic [31:0] w;
        logic [3:0]  exp_ce;
        bit          issued;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        #1;
        issued = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bram_ce != 4'h0) begin
                issued = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check_eq("issue_seen", {31'd0, issued}, 32'd1);
        exp_ce = (wstrb == 4'h0) ? 4'hF : wstrb;
        check_eq("bram_ce", {28'd0, bram_ce}, {28'd0, exp_ce});
        check_eq("bram_we", {28'd0, bram_we}, {28'd0, wstrb});
        check_eq("bram_addr", {22'd0, bram_addr}, {22'd0, addr[11:2]});
        if (wstrb != 4'h0) check_eq("bram_di", bram_di, wdata);
        w = ref_mem[addr[11:2]];
        e.is_read = (wstrb == 4'h0);
        e.data    = w;
        sb_q.push_back(e);
        exp_ready++;
        for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[addr[11:2]] = w;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk); #1;
            check_eq((c == LAT) ? "ready_at_lat" : "ready_early",
                     {31'd0, mem_ready}, (c == LAT) ? 32'd1 : 32'd0);
            check_eq("ce_after_issue", {28'd0, bram_ce}, 32'd0);
        end
        if (drop) mem_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 1024; i++) begin
            for (int n = 0; n < 4; n++) lane_mem[n][i] = 8'h00;
            ref_mem[i] = 32'h0000_0000;
        end
        for (int n = 0; n < 4; n++) lane_mem[n][0] = BOOT_WORD[8*n +: 8];
        ref_mem[0] = BOOT_WORD;

        // Reset state, including a hit presented while reset is held.
        resetn = 1'b0; mem_valid = 1'b1; mem_addr = 32'h4; mem_wdata = 32'h0; mem_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", {31'd0, mem_ready}, 32'd0);
        check_eq("rst_ce", {28'd0, bram_ce}, 32'd0);
        check_eq("rst_we", {28'd0, bram_we}, 32'd0);
        check_eq("bram_rst", {31'd0, bram_rst}, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        idle_cycle();

        // Full-word write, reads, partial-strobe write, ignored byte offset.
        do_txn(32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1); idle_cycle();
        do_txn(32'h0000_0004, 32'h0, 4'h0, 1'b1);         idle_cycle();
        do_txn(32'h0000_0004, 32'h1122_3344, 4'b0010, 1'b1); idle_cycle();
        do_txn(32'h0000_0004, 32'h0, 4'h0, 1'b1);         idle_cycle();
        do_txn(32'h0000_0007, 32'h0, 4'h0, 1'b1);         idle_cycle();
        do_txn(32'h0000_0FFC, 32'hCAFE_F00D, 4'b1001, 1'b1); idle_cycle();
        do_txn(32'h0000_0FFC, 32'h0, 4'h0, 1'b1);         idle_cycle();

        // Out-of-window request must be ignored for 20 cycles.
        mem_valid = 1'b1; mem_addr = 32'h0000_1000; mem_wstrb = 4'hF; mem_wdata = 32'h5555_AAAA;
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq("miss_ready", {31'd0, mem_ready}, 32'd0);
            check_eq("miss_ce", {28'd0, bram_ce}, 32'd0);
            @(negedge clk);
        end
        mem_valid = 1'b0;
        idle_cycle();

        // Back-to-back write then read with valid held high.
        do_txn(32'h0000_0008, 32'h0BAD_F00D, 4'hF, 1'b0);
        do_txn(32'h0000_0008, 32'h0, 4'h0, 1'b1);
        idle_cycle();

        // Reset asserted while a read is in flight: its mem_ready must never appear.
        mem_valid = 1'b1; mem_addr = 32'h4; mem_wstrb = 4'h0;
        #1;
        check_eq("abort_issue_ce", {28'd0, bram_ce}, 32'hF);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("abort_ce_in_rst", {28'd0, bram_ce}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_eq("abort_ready", {31'd0, mem_ready}, 32'd0);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_txn(32'h0000_0000, 32'h0, 4'h0, 1'b1);
        idle_cycle();

        // Random write/read pairs inside the window.
        for (int i = 0; i < 8; i++) begin
            a = {20'h0, 12'($urandom_range(0, 4095))};
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            do_txn(a, d, s, 1'b1); idle_cycle();
            do_txn(a, 32'h0, 4'h0, 1'b1); idle_cycle();
        end

        repeat (3) idle_cycle();
        check_eq("ready_count", ready_cnt, exp_ready);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
